// File: rtl/ro_puf_evaluator.sv
// Ring-oscillator PUF pair evaluator: per response bit, enables one oscillator pair,
// counts synchronised rising edges of both rings over a fixed window and compares them.
module ro_puf_evaluator #(
   parameter int N_BITS     = 8,
   parameter int SEL_W      = 3,
   parameter int CNT_W      = 16,
   parameter int WINDOW     = 1024,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ro_a,
   input  logic              ro_b,
   output logic              ro_en,
   output logic [SEL_W-1:0]  ro_sel,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] response,
   output logic              tie,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_COUNT   = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam int T_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam logic [T_W-1:0]   SETTLE_LAST = T_W'(SETTLE_CYC - 1);
   localparam logic [T_W-1:0]   WINDOW_LAST = T_W'(WINDOW - 1);
   localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(N_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   state_t              state_q, state_d;
   logic [T_W-1:0]      tmr_q, tmr_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [N_BITS-1:0]   resp_q, resp_d;
   logic                tie_q, tie_d;
   logic [2:0]          sa_q, sb_q;
   logic                edge_a, edge_b;

   // Two synchroniser flops then one history flop; the pipeline is flushed between bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q <= '0;
         sb_q <= '0;
      end else if (state_q == S_COMPARE) begin
         sa_q <= '0;
         sb_q <= '0;
      end else begin
         sa_q <= {sa_q[1:0], ro_a};
         sb_q <= {sb_q[1:0], ro_b};
      end
   end

   assign edge_a = sa_q[1] & ~sa_q[2];
   assign edge_b = sb_q[1] & ~sb_q[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         resp_q  <= '0;
         tie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
      end
   end

   // start is a level request looked at only in IDLE; done is a single-cycle
   // pulse after which response/tie stay valid until the next accepted start.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      cnt_a_d = '0;
      cnt_b_d = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               tmr_d   = '0;
               idx_d   = '0;
               resp_d  = '0;
               tie_d   = 1'b0;
            end
         end
         S_SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               tmr_d   = '0;
               state_d = S_COUNT;
            end else begin
               tmr_d = tmr_q + T_W'(1);
            end
         end
         S_COUNT: begin
            cnt_a_d = (edge_a && cnt_a_q != CNT_MAX) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
            cnt_b_d = (edge_b && cnt_b_q != CNT_MAX) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
            if (tmr_q == WINDOW_LAST) begin
               tmr_d   = '0;
               state_d = S_COMPARE;
            end else begin
               tmr_d = tmr_q + T_W'(1);
            end
         end
         S_COMPARE: begin
            resp_d[idx_q] = (cnt_a_q > cnt_b_q);
            if (cnt_a_q == cnt_b_q) tie_d = 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + SEL_W'(1);
               state_d = S_SETTLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign ro_en       = (state_q == S_SETTLE) || (state_q == S_COUNT);
   assign busy        = (state_q == S_SETTLE) || (state_q == S_COUNT) || (state_q == S_COMPARE);
   assign done        = (state_q == S_DONE);
   assign ro_sel      = idx_q;
   assign response    = resp_q;
   assign tie         = tie_q;
   assign dbg_state_o = state_q;

endmodule
